simplez_tx_port: RTL

Memory-mapped serial output peripheral that consumes the CPU data-bus writes that Simplez makes to its screen port. The CPU writes a character to the data address and polls the status address. The block serialises the character as 8N1 UART on a single pin. It sits on the CPU's busD/address path alongside the main memory and decodes its own two addresses.

---
 rtl/simplez_tx_port.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/simplez_tx_port.sv
// Simplez screen port: 8N1 UART transmitter on the CPU data bus.
// Define SIMPLEZ_TX_HOLD_EN for a one-entry holding register.
module simplez_tx_port #(
   parameter int DATAW     = 12,
   parameter int ADDRW     = 9,
   parameter int ADDR_STAT = 508,
   parameter int ADDR_DATA = 509,
   parameter int BAUD_DIV  = 104
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADDRW-1:0] addr,
   input  logic             rd,
   input  logic             wr,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             hit,
   output logic             tx,
   output logic             busy
);

   localparam int BW = $clog2(BAUD_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_n;
   logic [BW-1:0] baud_q, baud_n;
   logic [2:0]    bit_q, bit_n;
   logic [8:0]    sh_q, sh_n;
   logic          tx_q, tx_n;
   logic          busy_q, busy_n;
   logic          sel_stat, sel_data;
   logic          ready, accept, baud_end, go;
   logic [7:0]    go_byte;
   logic          unused_hi;

`ifdef SIMPLEZ_TX_HOLD_EN
   logic [7:0] hold_q, hold_n;
   logic       hold_full_q, hold_full_n;
   assign ready = ~hold_full_q;
`else
   assign ready = ~busy_q;
`endif

   assign sel_stat  = (addr == ADDRW'(ADDR_STAT));
   assign sel_data  = (addr == ADDRW'(ADDR_DATA));
   assign accept    = wr & sel_data & ready;
   assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
   assign unused_hi = ^data_in[DATAW-1:8];

   assign hit      = rd & sel_stat;
   assign data_out = hit ? {{(DATAW-1){1'b0}}, ready} : '1;
   assign tx       = tx_q;
   assign busy     = busy_q;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= 9'h1FF;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         sh_q    <= sh_n;
         tx_q    <= tx_n;
         busy_q  <= busy_n;
      end
   end

`ifdef SIMPLEZ_TX_HOLD_EN
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         hold_q      <= hold_n;
         hold_full_q <= hold_full_n;
      end
   end
`endif

   always_comb begin
      state_n = state_q;
      baud_n  = (state_q == IDLE || baud_end) ? '0 : baud_q + BW'(1);
      bit_n   = bit_q;
      sh_n    = sh_q;
      tx_n    = tx_q;
      busy_n  = busy_q;
      go      = 1'b0;
      go_byte = data_in[7:0];
`ifdef SIMPLEZ_TX_HOLD_EN
      hold_n      = hold_q;
      hold_full_n = hold_full_q;
`endif
      unique case (state_q)
         IDLE: go = accept;
         START: begin
            if (baud_end) begin
               tx_n    = sh_q[0];
               sh_n    = {1'b1, sh_q[8:1]};
               bit_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               if (bit_q == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  tx_n  = sh_q[0];
                  sh_n  = {1'b1, sh_q[8:1]};
                  bit_n = bit_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               state_n = IDLE;
               busy_n  = 1'b0;
`ifdef SIMPLEZ_TX_HOLD_EN
               // Held byte chains straight into the next start bit
               if (hold_full_q) begin
                  go          = 1'b1;
                  go_byte     = hold_q;
                  hold_full_n = 1'b0;
               end else begin
                  go = accept;
               end
`endif
            end
         end
         default: state_n = IDLE;
      endcase
`ifdef SIMPLEZ_TX_HOLD_EN
      if (accept && state_q != IDLE && !(state_q == STOP && baud_end)) begin
         hold_n      = data_in[7:0];
         hold_full_n = 1'b1;
      end
`endif
      if (go) begin
         state_n = START;
         tx_n    = 1'b0;
         busy_n  = 1'b1;
         baud_n  = '0;
         bit_n   = '0;
         sh_n    = {1'b1, go_byte};
      end
   end

endmodule
